// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator driven by a pixel clock-enable.
// Provides registered counters, sync/visible decode, raster strobes and a frame counter.
module vga_timing_gen #(
    parameter int PIX_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int CW       = 10,
    parameter int FW       = 8
) (
    input  logic          clk,
    input  logic          reset,
    output logic          pix_ce,
    output logic [CW-1:0] CounterX,
    output logic [CW-1:0] CounterY,
    output logic          inDisplayArea,
    output logic          vga_h_sync,
    output logic          vga_v_sync,
    output logic          line_start,
    output logic          frame_start,
    output logic          vblank_start,
    output logic [FW-1:0] frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW      = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam int XW      = CW + 1;

    if (PIX_DIV < 1 || H_TOTAL > (1 << CW) || V_TOTAL > (1 << CW)) begin : g_bad_params
        $fatal(1, "vga_timing_gen: PIX_DIV < 1 or raster totals exceed counter width");
    end

    localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);
    localparam logic [CW-1:0] X_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] Y_LAST   = CW'(V_TOTAL - 1);
    localparam logic [XW-1:0] H_ACT_W  = XW'(H_ACTIVE);
    localparam logic [XW-1:0] HS_BEG   = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] HS_END   = XW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [XW-1:0] V_ACT_W  = XW'(V_ACTIVE);
    localparam logic [XW-1:0] VS_BEG   = XW'(V_ACTIVE + V_FP);
    localparam logic [XW-1:0] VS_END   = XW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic          HS_ACT   = (HS_POL != 0);
    localparam logic          VS_ACT   = (VS_POL != 0);

    logic [DW-1:0] div_cnt;
    logic          x_wrap;
    logic          y_wrap;
    logic [CW-1:0] x_nxt;
    logic [CW-1:0] y_nxt;
    logic          disp_nxt;
    logic          hs_on_nxt;
    logic          vs_on_nxt;

    // Gating with the live reset keeps pix_ce low while reset is held, yet lets
    // PIX_DIV=1 advance in the very first clk after release.
    assign pix_ce = ~reset && (div_cnt == DIV_LAST);

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        x_wrap    = (CounterX == X_LAST);
        y_wrap    = (CounterY == Y_LAST);
        x_nxt     = x_wrap ? '0 : CounterX + CW'(1);
        y_nxt     = CounterY;
        if (x_wrap) begin
            y_nxt = y_wrap ? '0 : CounterY + CW'(1);
        end
        disp_nxt  = ({1'b0, x_nxt} < H_ACT_W) && ({1'b0, y_nxt} < V_ACT_W);
        hs_on_nxt = ({1'b0, x_nxt} >= HS_BEG) && ({1'b0, x_nxt} < HS_END);
        vs_on_nxt = ({1'b0, y_nxt} >= VS_BEG) && ({1'b0, y_nxt} < VS_END);
    end

    // Decode is registered from the next counter values so every output lines up.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt       <= '0;
            CounterX      <= '0;
            CounterY      <= '0;
            inDisplayArea <= 1'b0;
            vga_h_sync    <= ~HS_ACT;
            vga_v_sync    <= ~VS_ACT;
            line_start    <= 1'b0;
            frame_start   <= 1'b0;
            vblank_start  <= 1'b0;
            frame_count   <= '0;
        end else begin
            div_cnt      <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DW'(1);
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
            vblank_start <= 1'b0;
            if (pix_ce) begin
                CounterX      <= x_nxt;
                CounterY      <= y_nxt;
                inDisplayArea <= disp_nxt;
                vga_h_sync    <= hs_on_nxt ? HS_ACT : ~HS_ACT;
                vga_v_sync    <= vs_on_nxt ? VS_ACT : ~VS_ACT;
                line_start    <= x_wrap;
                frame_start   <= x_wrap && y_wrap;
                vblank_start  <= x_wrap && ({1'b0, y_nxt} == V_ACT_W);
                if (x_wrap && y_wrap) begin
                    frame_count <= frame_count + FW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: PIX_DIV=2 and PIX_DIV=1 instances checked every clk
// against an arithmetic raster model, with directed and random mid-frame resets.
module tb_vga_timing_gen;

    localparam int H_ACT = 4, H_FP = 1, H_SY = 2, H_BP = 1;
    localparam int V_ACT = 3, V_FP = 1, V_SY = 1, V_BP = 1;
    localparam int HT = H_ACT + H_FP + H_SY + H_BP;
    localparam int VT = V_ACT + V_FP + V_SY + V_BP;
    localparam int CW = 4, FW = 2;

    typedef struct {
        logic ce;
        int   x;
        int   y;
        logic disp;
        logic hs;
        logic vs;
        logic ls;
        logic fs;
        logic vb;
        int   fc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic          a_ce, a_disp, a_hs, a_vs, a_ls, a_fs, a_vb;
    logic [CW-1:0] a_x, a_y;
    logic [FW-1:0] a_fc;
    logic          b_ce, b_disp, b_hs, b_vs, b_ls, b_fs, b_vb;
    logic [CW-1:0] b_x, b_y;
    logic [FW-1:0] b_fc;

    int errors = 0;
    int checks = 0;
    int e = 0;
    int cyc = 0;
    int rst_at = -1;
    bit hold = 1'b1;
    int last_ls[2] = '{-1, -1};
    int last_fs[2] = '{-1, -1};

    always #5 clk = ~clk;

    vga_timing_gen #(
        .PIX_DIV(2), .H_ACTIVE(H_ACT), .H_FP(H_FP), .H_SYNC(H_SY), .H_BP(H_BP),
        .V_ACTIVE(V_ACT), .V_FP(V_FP), .V_SYNC(V_SY), .V_BP(V_BP),
        .HS_POL(0), .VS_POL(0), .CW(CW), .FW(FW)
    ) dut_div2 (
        .clk(clk), .reset(reset), .pix_ce(a_ce), .CounterX(a_x), .CounterY(a_y),
        .inDisplayArea(a_disp), .vga_h_sync(a_hs), .vga_v_sync(a_vs),
        .line_start(a_ls), .frame_start(a_fs), .vblank_start(a_vb), .frame_count(a_fc)
    );

    vga_timing_gen #(
        .PIX_DIV(1), .H_ACTIVE(H_ACT), .H_FP(H_FP), .H_SYNC(H_SY), .H_BP(H_BP),
        .V_ACTIVE(V_ACT), .V_FP(V_FP), .V_SYNC(V_SY), .V_BP(V_BP),
        .HS_POL(0), .VS_POL(0), .CW(CW), .FW(FW)
    ) dut_div1 (
        .clk(clk), .reset(reset), .pix_ce(b_ce), .CounterX(b_x), .CounterY(b_y),
        .inDisplayArea(b_disp), .vga_h_sync(b_hs), .vga_v_sync(b_vs),
        .line_start(b_ls), .frame_start(b_fs), .vblank_start(b_vb), .frame_count(b_fc)
    );

    // k is the clk index since the last reset edge (1 = release clk).
    function automatic exp_t model(input int k, input int div, input logic rst);
        exp_t m;
        int   n;
        int   p;
        logic act;
        logic first;
        n      = (k - 1) / div;
        p      = n % (HT * VT);
        m.x    = p % HT;
        m.y    = p / HT;
        act    = (n > 0);
        first  = act && ((k - 1) % div == 0);
        m.ce   = !rst && ((k - 1) % div == div - 1);
        m.disp = act && (m.x < H_ACT) && (m.y < V_ACT);
        m.hs   = !(act && m.x >= H_ACT + H_FP && m.x < H_ACT + H_FP + H_SY);
        m.vs   = !(act && m.y >= V_ACT + V_FP && m.y < V_ACT + V_FP + V_SY);
        m.ls   = first && (m.x == 0);
        m.fs   = m.ls && (m.y == 0);
        m.vb   = m.ls && (m.y == V_ACT);
        m.fc   = (n / (HT * VT)) % (1 << FW);
        return m;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d (clk %0d since reset)", tag, obs, exp_v, e + 1);
        end
    endtask

    task automatic check_dut(input int id, input string nm, input int div, input exp_t m,
                             input logic ce, input logic [CW-1:0] x, input logic [CW-1:0] y,
                             input logic disp, input logic hs, input logic vs, input logic ls,
                             input logic fs, input logic vb, input logic [FW-1:0] fc);
        check({nm, ".pix_ce"}, 32'(ce), 32'(m.ce));
        check({nm, ".x"}, 32'(x), m.x);
        check({nm, ".y"}, 32'(y), m.y);
        check({nm, ".disp"}, 32'(disp), 32'(m.disp));
        check({nm, ".hsync"}, 32'(hs), 32'(m.hs));
        check({nm, ".vsync"}, 32'(vs), 32'(m.vs));
        check({nm, ".line_start"}, 32'(ls), 32'(m.ls));
        check({nm, ".frame_start"}, 32'(fs), 32'(m.fs));
        check({nm, ".vblank_start"}, 32'(vb), 32'(m.vb));
        check({nm, ".frame_count"}, 32'(fc), m.fc);
        if (ls === 1'b1) begin
            if (last_ls[id] >= 0) check({nm, ".line_period"}, cyc - last_ls[id], HT * div);
            last_ls[id] = cyc;
        end
        if (fs === 1'b1) begin
            if (last_fs[id] >= 0) check({nm, ".frame_period"}, cyc - last_fs[id], HT * VT * div);
            last_fs[id] = cyc;
        end
    endtask

    // Check both DUTs mid-clk, then advance one clk and drive reset for the next one.
    task automatic cycle();
        @(negedge clk);
        check_dut(0, "div2", 2, model(e + 1, 2, reset),
                  a_ce, a_x, a_y, a_disp, a_hs, a_vs, a_ls, a_fs, a_vb, a_fc);
        check_dut(1, "div1", 1, model(e + 1, 1, reset),
                  b_ce, b_x, b_y, b_disp, b_hs, b_vs, b_ls, b_fs, b_vb, b_fc);
        @(posedge clk);
        cyc++;
        if (reset) begin
            e = 0;
            last_ls = '{-1, -1};
            last_fs = '{-1, -1};
        end else begin
            e++;
        end
        #1 reset = hold || (e == rst_at);
    endtask

    initial begin
        @(posedge clk);
        #1;
        repeat (4) cycle();
        hold  = 1'b0;
        reset = 1'b0;

        // One-clk reset while the PIX_DIV=2 raster sits at (6,4) of the seventh frame.
        rst_at = 2 * (HT * VT * 6 + 4 * HT + 6);
        repeat (rst_at + 40) cycle();

        for (int i = 0; i < 3; i++) begin
            int lead;
            lead   = int'($urandom_range(5, 300));
            rst_at = e + lead;
            repeat (lead + int'($urandom_range(2, 50))) cycle();
        end

        rst_at = -1;
        repeat (300) cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
